// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard controller (slave).
// Carries hazard sources from ID/EX/MEM and returns per-stage lock/flush controls plus status.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_memread;
    logic                  ex_branch_taken;
    logic                  ex_div_start;
    logic                  div_done;
    logic                  mem_req;
    logic                  mem_ready;

    logic                  pc_lock;
    logic                  ifid_lock;
    logic                  ifid_flush;
    logic                  idex_lock;
    logic                  idex_flush;
    logic                  exmem_lock;
    logic                  exmem_flush;
    logic                  memwb_lock;
    logic                  memwb_flush;
    logic                  mem_timeout;
    logic [31:0]           stall_count;
    logic [31:0]           flush_count;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_memread,
               ex_branch_taken, ex_div_start, div_done, mem_req, mem_ready,
        input  pc_lock, ifid_lock, ifid_flush, idex_lock, idex_flush,
               exmem_lock, exmem_flush, memwb_lock, memwb_flush,
               mem_timeout, stall_count, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_memread,
               ex_branch_taken, ex_div_start, div_done, mem_req, mem_ready,
        output pc_lock, ifid_lock, ifid_flush, idex_lock, idex_flush,
               exmem_lock, exmem_flush, memwb_lock, memwb_flush,
               mem_timeout, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline hazard controller: memory/divide stalls, branch redirect and load-use interlock.
// Optional performance counters are built only when PIPE_HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DIV_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_lock;
        logic ifid_lock;
        logic ifid_flush;
        logic idex_lock;
        logic idex_flush;
        logic exmem_lock;
        logic exmem_flush;
        logic memwb_lock;
        logic memwb_flush;
    } ctrl_t;

    state_t      state;
    state_t      state_next;
    ctrl_t       ctrl;
    logic [15:0] wait_cnt;
    logic        timeout_q;

    logic mem_stall;
    logic div_stall;
    logic branch_redirect;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic timeout_hit;

    // Hazard conditions in strict priority: memory > divide > branch > load-use.
    assign mem_stall       = hz.mem_req && !hz.mem_ready;
    assign div_stall       = !mem_stall && (hz.ex_div_start || (state == DIV_WAIT)) && !hz.div_done;
    assign branch_redirect = !mem_stall && !div_stall && hz.ex_branch_taken;

    assign rs1_hit  = hz.id_rs1_used && (hz.id_rs1 == hz.ex_rd);
    assign rs2_hit  = hz.id_rs2_used && (hz.id_rs2 == hz.ex_rd);
    assign load_use = !mem_stall && !div_stall && !hz.ex_branch_taken && hz.ex_memread
                      && (hz.ex_rd != REG_ADDR_W'(0)) && (rs1_hit || rs2_hit);

    assign timeout_hit = (state == MEM_WAIT) && (wait_cnt == 16'(MEM_TIMEOUT));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: each combinational output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        state_next = RUN;
        if (mem_stall) begin
            state_next = MEM_WAIT;
        end else if (div_stall) begin
            state_next = DIV_WAIT;
        end
    end

    // Controls are forced idle while reset is held, independent of the hazard inputs.
    always_comb begin
        ctrl = '0;
        if (!rst) begin
            if (mem_stall) begin
                ctrl.pc_lock     = 1'b1;
                ctrl.ifid_lock   = 1'b1;
                ctrl.idex_lock   = 1'b1;
                ctrl.exmem_lock  = 1'b1;
                ctrl.memwb_flush = 1'b1;
            end else if (div_stall) begin
                ctrl.pc_lock     = 1'b1;
                ctrl.ifid_lock   = 1'b1;
                ctrl.idex_lock   = 1'b1;
                ctrl.exmem_flush = 1'b1;
            end else if (branch_redirect) begin
                ctrl.ifid_flush  = 1'b1;
                ctrl.idex_flush  = 1'b1;
            end else if (load_use) begin
                ctrl.pc_lock     = 1'b1;
                ctrl.ifid_lock   = 1'b1;
                ctrl.idex_flush  = 1'b1;
            end
        end
    end

    // Wait counter counts consecutive stalled memory cycles and saturates; timeout is sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (mem_stall) begin
                if (wait_cnt != 16'hFFFF) begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
            end else begin
                wait_cnt <= '0;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign hz.pc_lock     = ctrl.pc_lock;
    assign hz.ifid_lock   = ctrl.ifid_lock;
    assign hz.ifid_flush  = ctrl.ifid_flush;
    assign hz.idex_lock   = ctrl.idex_lock;
    assign hz.idex_flush  = ctrl.idex_flush;
    assign hz.exmem_lock  = ctrl.exmem_lock;
    assign hz.exmem_flush = ctrl.exmem_flush;
    assign hz.memwb_lock  = ctrl.memwb_lock;
    assign hz.memwb_flush = ctrl.memwb_flush;
    assign hz.mem_timeout = timeout_q || timeout_hit;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (ctrl.pc_lock && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (ctrl.ifid_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign hz.stall_count = stall_cnt_q;
    assign hz.flush_count = flush_cnt_q;
`else
    assign hz.stall_count = '0;
    assign hz.flush_count = '0;
`endif

endmodule
